bm_match_mac_pipe: RTL and testbench
====================================

Name: bm_match_mac_pipe

Overview:
- Parametrised, pipelined multiply-add / multiply-accumulate primitive for the ODIN_II micro-benchmark suite.
- Generalises registered "d + e*f" style expressions with:
  - configurable operand width, result width and multiplier depth;
  - a per-sample mode bit selecting multiply-add or block accumulation over ACC_LEN samples;
  - valid qualification, overflow detection and a clear input.
- Exercises hard-multiplier inference, pipelining and a small accumulate FSM in one block.

Parameters:
- DATA_W, 9, unsigned operand width.
- ACC_W, 24, result/accumulator width; must be >= 2*DATA_W.
- MUL_STAGES, 2, register stages inside the multiplier; >= 1.
- ACC_LEN, 4, samples per accumulation block; >= 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe.
- in_mode  in  1  0 = MADD (a*b+c), 1 = ACC (accumulate a*b).
- a_in  in  DATA_W  multiplicand.
- b_in  in  DATA_W  multiplier.
- c_in  in  DATA_W  addend, used in MADD only.
- acc_clear  in  1  discards the partial accumulation.
- out_valid  out  1  result strobe, one cycle.
- out_data  out  ACC_W  result.
- out_mode  out  1  mode of the emitted result.
- out_ovf  out  1  wrap occurred in this result.
- busy  out  1  a partial ACC block is held.

Behaviour:
- Reset: all pipeline registers, accumulator, sample count, out_valid, out_data, out_mode, out_ovf and busy go to 0 immediately. In-flight samples are dropped. No output is emitted for them after reset is released.
- Arithmetic:
  - All arithmetic is unsigned.
  - The product is 2*DATA_W bits and is zero-extended to ACC_W.
  - Addition wraps modulo 2^ACC_W.
  - out_ovf = carry-out of the final add (MADD), or OR of all carries across the block (ACC).
- Pipeline:
  - Sample accepted on the clock edge with in_valid=1.
  - mode and c travel alongside the multiplier pipeline.
  - Product is ready after MUL_STAGES cycles, then one add/accumulate stage.
  - Latency L = MUL_STAGES+1: a sample accepted at edge n yields its result at edge n+L. Default L=3.
- Throughput:
  - One sample per cycle; in_valid gaps allowed.
  - No backpressure; the block is always ready.
- MADD sample at the add stage:
  - out_data = a*b + c; out_mode=0; out_valid=1.
  - Accumulator, count and busy are untouched.
- ACC sample at the add stage:
  - acc += a*b; count increments.
  - When count reaches ACC_LEN: out_data = final sum, out_mode=1, out_valid=1. Accumulator, count and the sticky ovf then return to 0 in the same edge.
  - Otherwise out_valid=0.
- FSM:
  - IDLE (count=0) and ACCUM (count>0); busy = state==ACCUM.
  - IDLE -> ACCUM on the first ACC sample.
  - ACCUM -> IDLE on block completion or acc_clear.
- Interleaving: MADD samples may arrive mid-block. They bypass the accumulator, and the partial block is retained.
- acc_clear:
  - Synchronous, applied at the add stage: zeroes acc, count and sticky ovf.
  - Samples still in the multiplier are unaffected.
  - If asserted in the same cycle that an ACC sample reaches the add stage, clear wins: that sample is discarded and no output is produced.
  - A MADD sample in that cycle still emits normally.
- Hold: out_data, out_mode and out_ovf keep their last values when out_valid=0.

Decomposition:
- Package bm_mac_pkg holds:
  - mode constants MODE_MADD=0 and MODE_ACC=1;
  - FSM state encodings ST_IDLE and ST_ACCUM;
  - a latency function returning MUL_STAGES+1.
- One sub-module, bm_pipe_mult: a DATA_W x DATA_W unsigned multiplier with MUL_STAGES output registers and a valid/sideband shift register of matching depth.
- The top holds the add stage, accumulator, counter and FSM.

Test Plan:
1. MADD max: a=511, b=511, c=511 at edge 0 -> out_valid at edge 3, out_data=261632, out_mode=0, out_ovf=0, busy stays 0.
2. ACC block: back-to-back samples (10,10), (20,20), (30,30), (40,40) -> one out_valid at edge 6, out_data=3000, out_mode=1; busy is 1 from edge 3 until edge 6, when it returns to 0.
3. Overflow with ACC_W=18: four ACC samples of 511*511 -> out_data=258052, out_ovf=1. A following MADD 1*1+0 -> out_data=1, out_ovf=0.
4. Interleave: ACC (3,3), ACC (4,4), MADD (2,2,c=5), ACC (1,1), ACC (2,2) -> MADD result 9 emitted at its slot; ACC result 30 emitted 2 cycles later.
5. Clear: two ACC samples (7,7), then acc_clear pulse once both have been accumulated, then four ACC (1,1) -> single output of 4. Clear coinciding with the 4th ACC sample at the add stage -> no output; busy=0.
6. Reset mid-operation: two ACC and one MADD sample in flight, assert reset for 1 cycle -> all outputs 0 and no out_valid afterwards. Then four ACC (2,3) -> out_data=24.

Source files
------------

// File: rtl/bm_match_mac_pipe_pkg.sv
// Shared constants, FSM encodings and latency helper for the MAC pipeline.
package bm_mac_pkg;

    localparam logic MODE_MADD = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Edge distance from sample acceptance to its result strobe.
    function automatic int latency(input int mul_stages);
        return mul_stages + 1;
    endfunction

endpackage

// File: rtl/bm_match_mac_pipe_if.sv
// Sample/result bus of the MAC pipeline; master drives samples, slave is the block.
interface bm_match_mac_pipe_if #(
    parameter int DATA_W = 9,
    parameter int ACC_W  = 24
);
    logic              in_valid;
    logic              in_mode;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [DATA_W-1:0] c_in;
    logic              acc_clear;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_mode;
    logic              out_ovf;
    logic              busy;

    modport master (
        output in_valid, in_mode, a_in, b_in, c_in, acc_clear,
        input  out_valid, out_data, out_mode, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_mode, a_in, b_in, c_in, acc_clear,
        output out_valid, out_data, out_mode, out_ovf, busy
    );
endinterface

// File: rtl/bm_match_mac_pipe_mult.sv
// Unsigned DATA_W x DATA_W multiplier with MUL_STAGES output registers; valid
// and sideband bits ride a shift register of the same depth.
module bm_pipe_mult #(
    parameter int DATA_W     = 9,
    parameter int MUL_STAGES = 2,
    parameter int SB_W       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    input  logic [SB_W-1:0]       i_sb,
    output logic                  o_valid,
    output logic [2*DATA_W-1:0]   o_prod,
    output logic [SB_W-1:0]       o_sb
);

    logic [MUL_STAGES-1:0][2*DATA_W-1:0] r_prod;
    logic [MUL_STAGES-1:0][SB_W-1:0]     r_sb;
    logic [MUL_STAGES-1:0]               r_vld;
    logic [2*DATA_W-1:0]                 w_prod;

    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

    // Product, valid and sideband advance together one stage per clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prod <= '0;
            r_sb   <= '0;
            r_vld  <= '0;
        end else begin
            r_prod[0] <= w_prod;
            r_sb[0]   <= i_sb;
            r_vld[0]  <= i_valid;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_sb[i]   <= r_sb[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
        end
    end

    assign o_valid = r_vld[MUL_STAGES-1];
    assign o_prod  = r_prod[MUL_STAGES-1];
    assign o_sb    = r_sb[MUL_STAGES-1];

endmodule

// File: rtl/bm_match_mac_pipe.sv
// Pipelined multiply-add / block multiply-accumulate. Input register, then the
// multiplier, then one add stage that either emits a*b+c or accumulates a*b.
module bm_match_mac_pipe
    import bm_mac_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int ACC_W      = 24,
    parameter int MUL_STAGES = 2,
    parameter int ACC_LEN    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    bm_match_mac_pipe_if.slave   bus
);

    localparam int CNT_W = (ACC_LEN > 2) ? $clog2(ACC_LEN) : 1;

    logic              r_in_vld;
    logic              r_in_mode;
    logic [DATA_W-1:0] r_a, r_b, r_c;

    logic              w_m_vld;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W:0]   w_sb;
    logic              w_mode;
    logic [ACC_W-1:0]  w_prod_ext, w_c_ext;
    logic [ACC_W:0]    w_madd_sum, w_acc_sum;
    logic              w_is_madd, w_is_acc, w_last;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf_sticky;
    state_t            r_state, w_state_nx;
    logic              w_busy;

    logic              r_out_valid, r_out_mode, r_out_ovf;
    logic [ACC_W-1:0]  r_out_data;

    // Sample acceptance register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_vld  <= 1'b0;
            r_in_mode <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
        end else begin
            r_in_vld  <= bus.in_valid;
            r_in_mode <= bus.in_mode;
            r_a       <= bus.a_in;
            r_b       <= bus.b_in;
            r_c       <= bus.c_in;
        end
    end

    bm_pipe_mult #(
        .DATA_W     (DATA_W),
        .MUL_STAGES (MUL_STAGES),
        .SB_W       (DATA_W + 1)
    ) u_mult (
        .clock   (clock),
        .reset   (reset),
        .i_valid (r_in_vld),
        .i_a     (r_a),
        .i_b     (r_b),
        .i_sb    ({r_in_mode, r_c}),
        .o_valid (w_m_vld),
        .o_prod  (w_prod),
        .o_sb    (w_sb)
    );

    assign w_mode = w_sb[DATA_W];

    // Zero-extend product and addend to accumulator width; carries come from bit ACC_W.
    always_comb begin
        w_prod_ext                = '0;
        w_prod_ext[2*DATA_W-1:0]  = w_prod;
        w_c_ext                   = '0;
        w_c_ext[DATA_W-1:0]       = w_sb[DATA_W-1:0];
        w_madd_sum = {1'b0, w_prod_ext} + {1'b0, w_c_ext};
        w_acc_sum  = {1'b0, r_acc} + {1'b0, w_prod_ext};
    end

    // Clear outranks an ACC sample arriving in the same cycle; MADD is unaffected.
    assign w_is_madd = w_m_vld && (w_mode == MODE_MADD);
    assign w_is_acc  = w_m_vld && (w_mode == MODE_ACC) && !bus.acc_clear;
    assign w_last    = w_is_acc && (r_cnt == CNT_W'(ACC_LEN - 1));

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // FSM next state: a block opens on its first ACC sample, closes on completion or clear.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_is_acc) w_state_nx = ST_ACCUM;
            ST_ACCUM: if (bus.acc_clear || w_last) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_busy = (r_state == ST_ACCUM);
    end

    // Accumulator, sample count and sticky carry of the open block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (bus.acc_clear || w_last) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (w_is_acc) begin
            r_acc        <= w_acc_sum[ACC_W-1:0];
            r_cnt        <= r_cnt + CNT_W'(1);
            r_ovf_sticky <= r_ovf_sticky | w_acc_sum[ACC_W];
        end
    end

    // Result register: one-cycle strobe, data/mode/ovf hold between results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mode  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_is_madd) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_madd_sum[ACC_W-1:0];
                r_out_mode  <= MODE_MADD;
                r_out_ovf   <= w_madd_sum[ACC_W];
            end else if (w_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_sum[ACC_W-1:0];
                r_out_mode  <= MODE_ACC;
                r_out_ovf   <= r_ovf_sticky | w_acc_sum[ACC_W];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_mode  = r_out_mode;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_bm_match_mac_pipe.sv
// Directed bench for bm_match_mac_pipe: a reference model pushes expected
// results when samples are driven, monitors pop and compare on out_valid.
module tb_bm_match_mac_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bm_match_mac_pipe_if #(.DATA_W(9), .ACC_W(24)) if0 ();
    bm_match_mac_pipe_if #(.DATA_W(9), .ACC_W(18)) if1 ();

    bm_match_mac_pipe #(.DATA_W(9), .ACC_W(24), .MUL_STAGES(2), .ACC_LEN(4))
        u_dut0 (.clock(clk), .reset(rst), .bus(if0));
    bm_match_mac_pipe #(.DATA_W(9), .ACC_W(18), .MUL_STAGES(2), .ACC_LEN(4))
        u_dut1 (.clock(clk), .reset(rst), .bus(if1));

    typedef struct {
        logic [23:0] d;
        logic        m;
        logic        o;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    longint m_sum[2];
    int     m_cnt[2];
    int     n_cmp  = 0;
    int     n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, wrap and carry derived from the true sum.
    task automatic model(input bit sel, input longint a, input longint b,
                         input longint c, input bit mode);
        longint lim;
        longint full;
        exp_t   e;
        lim = sel ? (64'd1 << 18) : (64'd1 << 24);
        if (mode == 1'b0) begin
            full = a * b + c;
            e.d = 24'(full % lim);
            e.m = 1'b0;
            e.o = (full >= lim);
            if (sel) q1.push_back(e); else q0.push_back(e);
        end else begin
            m_sum[sel] += a * b;
            m_cnt[sel]++;
            if (m_cnt[sel] == 4) begin
                e.d = 24'(m_sum[sel] % lim);
                e.m = 1'b1;
                e.o = (m_sum[sel] >= lim);
                if (sel) q1.push_back(e); else q0.push_back(e);
                m_sum[sel] = 0;
                m_cnt[sel] = 0;
            end
        end
    endtask

    task automatic drive_idle();
        if0.in_valid = 1'b0; if0.in_mode = 1'b0;
        if0.a_in = '0; if0.b_in = '0; if0.c_in = '0;
        if1.in_valid = 1'b0; if1.in_mode = 1'b0;
        if1.a_in = '0; if1.b_in = '0; if1.c_in = '0;
    endtask

    // Drive one sample at the falling edge; it is accepted on the next rising edge.
    task automatic send(input bit sel, input int a, input int b, input int c,
                        input bit mode, input bit mdl = 1'b1);
        @(negedge clk);
        drive_idle();
        if (sel) begin
            if1.in_valid = 1'b1; if1.in_mode = mode;
            if1.a_in = 9'(a); if1.b_in = 9'(b); if1.c_in = 9'(c);
        end else begin
            if0.in_valid = 1'b1; if0.in_mode = mode;
            if0.a_in = 9'(a); if0.b_in = 9'(b); if0.c_in = 9'(c);
        end
        if (mdl) model(sel, a, b, c, mode);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    // Scoreboard monitors.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (if0.out_valid === 1'b1) begin
            if (q0.size() == 0) check("unexpected_out0", q0.size(), 1);
            else begin
                e = q0.pop_front();
                check("data0", if0.out_data, e.d);
                check("mode0", if0.out_mode, e.m);
                check("ovf0",  if0.out_ovf,  e.o);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (if1.out_valid === 1'b1) begin
            if (q1.size() == 0) check("unexpected_out1", q1.size(), 1);
            else begin
                e = q1.pop_front();
                check("data1", if1.out_data, e.d);
                check("mode1", if1.out_mode, e.m);
                check("ovf1",  if1.out_ovf,  e.o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive_idle();
        if0.acc_clear = 1'b0;
        if1.acc_clear = 1'b0;
        m_sum[0] = 0; m_sum[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", if0.out_valid, 0);
        check("rst_data",  if0.out_data,  0);
        check("rst_busy",  if0.busy,      0);
        check("rst_ovf",   if0.out_ovf,   0);
        rst = 1'b0;
        idle(2);

        // MADD max value, exact latency of 3 edges.
        send(0, 511, 511, 511, 0);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        check("t1_early", if0.out_valid, 0);
        @(negedge clk);
        check("t1_valid", if0.out_valid, 1);
        check("t1_data",  if0.out_data,  261632);
        check("t1_busy",  if0.busy,      0);
        idle(3);

        // ACC block of four back-to-back samples; busy window.
        send(0, 10, 10, 0, 1);
        send(0, 20, 20, 0, 1);
        send(0, 30, 30, 0, 1);
        send(0, 40, 40, 0, 1);
        idle(1);
        check("t2_busy_e3", if0.busy, 1);
        idle(2);
        check("t2_busy_e5", if0.busy, 1);
        check("t2_nv_e5",   if0.out_valid, 0);
        idle(1);
        check("t2_busy_e6", if0.busy, 0);
        check("t2_valid",   if0.out_valid, 1);
        check("t2_data",    if0.out_data, 3000);
        idle(3);

        // Overflow on the narrow instance, then a clean MADD.
        repeat (4) send(1, 511, 511, 0, 1);
        send(1, 1, 1, 0, 0);
        idle(8);
        check("t3_busy", if1.busy, 0);

        // MADD interleaved inside an ACC block.
        send(0, 3, 3, 0, 1);
        send(0, 4, 4, 0, 1);
        send(0, 2, 2, 5, 0);
        send(0, 1, 1, 0, 1);
        send(0, 2, 2, 0, 1);
        idle(8);

        // Clear after two accumulated samples, then a fresh block.
        send(0, 7, 7, 0, 1);
        send(0, 7, 7, 0, 1);
        idle(4);
        check("t5_busy_pre", if0.busy, 1);
        if0.acc_clear = 1'b1;
        m_sum[0] = 0; m_cnt[0] = 0;
        @(negedge clk);
        if0.acc_clear = 1'b0;
        check("t5_busy_clr", if0.busy, 0);
        repeat (4) send(0, 1, 1, 0, 1);
        idle(8);

        // Clear coinciding with the 4th ACC sample at the add stage.
        repeat (4) send(0, 5, 5, 0, 1, 1'b0);
        idle(3);
        check("t5b_busy_pre", if0.busy, 1);
        if0.acc_clear = 1'b1;
        @(negedge clk);
        if0.acc_clear = 1'b0;
        check("t5b_busy", if0.busy, 0);
        check("t5b_nv",   if0.out_valid, 0);
        idle(4);

        // Reset with samples in flight.
        send(0, 2, 3, 0, 1);
        send(0, 2, 3, 0, 1);
        send(0, 4, 4, 4, 0);
        idle(1);
        rst = 1'b1;
        q0.delete();
        m_sum[0] = 0; m_cnt[0] = 0;
        #1;
        check("t6_valid", if0.out_valid, 0);
        check("t6_data",  if0.out_data,  0);
        check("t6_busy",  if0.busy,      0);
        check("t6_mode",  if0.out_mode,  0);
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        repeat (4) send(0, 2, 3, 0, 1);
        idle(8);

        check("drain0", q0.size(), 0);
        check("drain1", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
